// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-word width, the NOP/bubble control
// pattern used by the ID/EX, IF/ID and EX/MEM flush logic, and stage FSM states.
package mips_pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 9;

    // Control pattern that makes an instruction slot architecturally inert
    localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL_DEF = 9'b001100000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stage_state_e;

endpackage

// File: rtl/bubble_stall_counter.sv
// Loadable down-counter backing the multi-cycle stall of the ID/EX stage.
// Clear beats hold, hold beats load/decrement. o_last is registered and is
// high exactly while the stored count equals 1.
module bubble_stall_counter #(
    parameter int unsigned SW = 2
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_hold,
    input  logic          i_load,
    input  logic [SW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_last
);

    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_nxt;

    // Next count: clear > hold > load > decrement
    always_comb begin
        cnt_nxt = cnt;
        if (i_clear) begin
            cnt_nxt = '0;
        end else if (i_hold) begin
            cnt_nxt = cnt;
        end else if (i_load) begin
            cnt_nxt = i_load_val;
        end else if (i_dec && (cnt != '0)) begin
            cnt_nxt = cnt - SW'(1);
        end
    end

    // Count register and its "one remaining" flag
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt    <= '0;
            o_last <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            o_last <= (cnt_nxt == SW'(1));
        end
    end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID/EX control-register stage with hazard bubble insertion, flush and halt.
// Optional feature macro: ID_EX_BUBBLE_STATS_EN adds a saturating count of
// hazard-injected bubbles on o_bubble_count.
module id_ex_control_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W      = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF),
    parameter int unsigned        MAX_STALL   = 3
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic [CTRL_W-1:0]                    i_control,
    input  logic                                 i_valid,
    input  logic                                 i_burbuja,
    input  logic                                 i_stall_req,
    input  logic [$clog2(MAX_STALL + 1)-1:0]     i_stall_cycles,
    input  logic                                 i_flush,
    input  logic                                 i_halt,
    output logic [CTRL_W-1:0]                    o_control,
    output logic                                 o_valid,
    output logic                                 o_stall_pc,
    output logic                                 o_busy
`ifdef ID_EX_BUBBLE_STATS_EN
    ,
    output logic [15:0]                          o_bubble_count
`endif
);

    localparam int unsigned    SW    = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0]  MAX_N = SW'(MAX_STALL);

    stage_state_e        state;
    stage_state_e        state_nxt;
    logic [SW-1:0]       n_sat;
    logic                stall_go;
    logic                cnt_last;
    logic                cnt_load;
    logic [CTRL_W-1:0]   control_nxt;
    logic                valid_nxt;

    // Clamp the requested stall length; a zero-length request is a no-op
    always_comb begin
        n_sat    = (i_stall_cycles > MAX_N) ? MAX_N : i_stall_cycles;
        stall_go = i_stall_req && (n_sat != '0);
        cnt_load = (state == ST_RUN) && stall_go && (n_sat > SW'(1));
    end

    bubble_stall_counter #(
        .SW (SW)
    ) u_cnt (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (i_flush),
        .i_hold     (i_halt),
        .i_load     (cnt_load),
        .i_load_val (n_sat - SW'(1)),
        .i_dec      (state == ST_STALL),
        .o_last     (cnt_last)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush > halt > stall sequencing
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = ST_RUN;
        end else if (!i_halt) begin
            case (state)
                ST_RUN:   if (cnt_load) state_nxt = ST_STALL;
                ST_STALL: if (cnt_last) state_nxt = ST_RUN;
                default:  state_nxt = ST_RUN;
            endcase
        end
    end

    // Next EX control/valid and the combinational IF/ID hold
    always_comb begin
        control_nxt = o_control;
        valid_nxt   = o_valid;
        o_stall_pc  = 1'b0;
        if (i_flush) begin
            control_nxt = BUBBLE_CTRL;
            valid_nxt   = 1'b0;
        end else if (i_halt) begin
            o_stall_pc  = 1'b1;
        end else if ((state == ST_STALL) || i_burbuja || stall_go) begin
            control_nxt = BUBBLE_CTRL;
            valid_nxt   = 1'b0;
            o_stall_pc  = 1'b1;
        end else begin
            control_nxt = i_control;
            valid_nxt   = i_valid;
        end
    end

    // Registered outputs to EX
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_control <= BUBBLE_CTRL;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_control <= control_nxt;
            o_valid   <= valid_nxt;
            o_busy    <= (state_nxt == ST_STALL);
        end
    end

`ifdef ID_EX_BUBBLE_STATS_EN
    logic hazard_bubble;

    // A bubble caused by a hazard, not by flush, halt or reset
    always_comb begin
        hazard_bubble = !i_flush && !i_halt &&
                        ((state == ST_STALL) || i_burbuja || stall_go);
    end

    // Saturating hazard-bubble counter
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_bubble_count <= 16'h0000;
        end else if (hazard_bubble && (o_bubble_count != 16'hFFFF)) begin
            o_bubble_count <= o_bubble_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Directed bench for id_ex_control_stage. A second instance with MAX_STALL=2
// exercises clamping of the requested stall length.
module tb_id_ex_control_stage;

    localparam logic [8:0] BUB = 9'b001100000;

    logic       clk;
    logic       rst;
    logic [8:0] control;
    logic       valid;
    logic       burbuja;
    logic       stall_req;
    logic [1:0] stall_cycles;
    logic       flush;
    logic       halt;

    logic [8:0] o_control;
    logic       o_valid;
    logic       o_stall_pc;
    logic       o_busy;
    logic [8:0] s_control;
    logic       s_valid;
    logic       s_stall_pc;
    logic       s_busy;
`ifdef ID_EX_BUBBLE_STATS_EN
    logic [15:0] o_bubble_count;
    logic [15:0] s_bubble_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    id_ex_control_stage #(.MAX_STALL(3)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_control      (control),
        .i_valid        (valid),
        .i_burbuja      (burbuja),
        .i_stall_req    (stall_req),
        .i_stall_cycles (stall_cycles),
        .i_flush        (flush),
        .i_halt         (halt),
        .o_control      (o_control),
        .o_valid        (o_valid),
        .o_stall_pc     (o_stall_pc),
        .o_busy         (o_busy)
`ifdef ID_EX_BUBBLE_STATS_EN
        ,
        .o_bubble_count (o_bubble_count)
`endif
    );

    id_ex_control_stage #(.MAX_STALL(2)) dut_s (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_control      (control),
        .i_valid        (valid),
        .i_burbuja      (burbuja),
        .i_stall_req    (stall_req),
        .i_stall_cycles (stall_cycles),
        .i_flush        (flush),
        .i_halt         (halt),
        .o_control      (s_control),
        .o_valid        (s_valid),
        .o_stall_pc     (s_stall_pc),
        .o_busy         (s_busy)
`ifdef ID_EX_BUBBLE_STATS_EN
        ,
        .o_bubble_count (s_bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check registered EX outputs of the main instance
    task automatic check_ex(input string tag, input logic [8:0] c, input logic v, input logic b);
        check({tag, ".control"}, 16'(o_control), 16'(c));
        check({tag, ".valid"},   16'(o_valid),   16'(v));
        check({tag, ".busy"},    16'(o_busy),    16'(b));
    endtask

    initial begin
        rst = 1'b1; control = 9'h000; valid = 1'b0; burbuja = 1'b0;
        stall_req = 1'b0; stall_cycles = 2'd0; flush = 1'b0; halt = 1'b0;
        tick(); tick();
        check_ex("reset", BUB, 1'b0, 1'b0);
        check("reset.stall_pc", 16'(o_stall_pc), 16'(0));
`ifdef ID_EX_BUBBLE_STATS_EN
        check("reset.count", o_bubble_count, 16'd0);
`endif

        // Normal pass-through
        rst = 1'b0; control = 9'h0A5; valid = 1'b1; #1;
        check("pass.stall_pc", 16'(o_stall_pc), 16'(0));
        tick();
        check_ex("pass", 9'h0A5, 1'b1, 1'b0);

        // Single-cycle load-use bubble
        control = 9'h1B3; burbuja = 1'b1; #1;
        check("burb.stall_pc", 16'(o_stall_pc), 16'(1));
        tick();
        burbuja = 1'b0; #1;
        check_ex("burb.bubble", BUB, 1'b0, 1'b0);
        check("burb.release", 16'(o_stall_pc), 16'(0));
        tick();
        check_ex("burb.held", 9'h1B3, 1'b1, 1'b0);

        // Three-cycle stall
        control = 9'h111; stall_req = 1'b1; stall_cycles = 2'd3; #1;
        check("st3.pc0", 16'(o_stall_pc), 16'(1));
        tick();
        stall_req = 1'b0; #1;
        check_ex("st3.b1", BUB, 1'b0, 1'b1);
        check("st3.pc1", 16'(o_stall_pc), 16'(1));
        tick(); #1;
        check_ex("st3.b2", BUB, 1'b0, 1'b1);
        check("st3.pc2", 16'(o_stall_pc), 16'(1));
        tick(); #1;
        check_ex("st3.b3", BUB, 1'b0, 1'b0);
        check("st3.pc3", 16'(o_stall_pc), 16'(0));
        tick();
        check_ex("st3.held", 9'h111, 1'b1, 1'b0);

        // Request of 3 on a MAX_STALL=2 stage clamps to 2 bubbles
        control = 9'h0C3; stall_req = 1'b1; stall_cycles = 2'd3; #1;
        check("sat.pc0", 16'(s_stall_pc), 16'(1));
        tick();
        stall_req = 1'b0; #1;
        check("sat.b1", 16'(s_control), 16'(BUB));
        check("sat.busy1", 16'(s_busy), 16'(1));
        check("sat.pc1", 16'(s_stall_pc), 16'(1));
        tick(); #1;
        check("sat.b2", 16'(s_control), 16'(BUB));
        check("sat.busy2", 16'(s_busy), 16'(0));
        check("sat.pc2", 16'(s_stall_pc), 16'(0));
        tick();
        check("sat.held", 16'(s_control), 16'(9'h0C3));
        check("sat.main_b3", 16'(o_control), 16'(BUB));
        tick();
        check_ex("sat.main_held", 9'h0C3, 1'b1, 1'b0);

        // Zero-length stall request is ignored
        control = 9'h0F0; stall_req = 1'b1; stall_cycles = 2'd0; #1;
        check("zero.stall_pc", 16'(o_stall_pc), 16'(0));
        tick();
        stall_req = 1'b0;
        check_ex("zero.pass", 9'h0F0, 1'b1, 1'b0);

        // Flush in the second cycle of a three-cycle stall
        control = 9'h155; stall_req = 1'b1; stall_cycles = 2'd3;
        tick();
        stall_req = 1'b0; flush = 1'b1; #1;
        check("flush.stall_pc", 16'(o_stall_pc), 16'(0));
        tick();
        flush = 1'b0; control = 9'h0AA; #1;
        check_ex("flush.bubble", BUB, 1'b0, 1'b0);
        check("flush.run_pc", 16'(o_stall_pc), 16'(0));
        tick();
        check_ex("flush.next", 9'h0AA, 1'b1, 1'b0);

        // Reset while stalled returns to RUN with no residual hold
        control = 9'h077; stall_req = 1'b1; stall_cycles = 2'd3;
        tick();
        stall_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check_ex("rst_stall", BUB, 1'b0, 1'b0);
        check("rst_stall.pc", 16'(o_stall_pc), 16'(0));

        // Halt for four cycles in the middle of a three-cycle stall
        control = 9'h033; stall_req = 1'b1; stall_cycles = 2'd3;
        tick();
        stall_req = 1'b0; halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("halt.pc", 16'(o_stall_pc), 16'(1));
            tick();
            check_ex("halt.frozen", BUB, 1'b0, 1'b1);
        end
        halt = 1'b0; #1;
        check("halt.resume_pc", 16'(o_stall_pc), 16'(1));
        tick(); #1;
        check_ex("halt.b2", BUB, 1'b0, 1'b1);
        check("halt.pc2", 16'(o_stall_pc), 16'(1));
        tick(); #1;
        check_ex("halt.b3", BUB, 1'b0, 1'b0);
        check("halt.pc3", 16'(o_stall_pc), 16'(0));
        tick();
        check_ex("halt.held", 9'h033, 1'b1, 1'b0);
`ifdef ID_EX_BUBBLE_STATS_EN
        check("halt.count", o_bubble_count, 16'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
